mdu: RTL and testbench
======================

# mdu

Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU. It latches two 32-bit operands on `start` and counts a fixed latency while `busy` is high. It then commits a 64-bit product, or quotient and remainder, into the architectural HI/LO registers. The hazard unit stalls on `start | busy` for any instruction that touches HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops.
- `DIV_CYCLES`, default 10: busy cycles for divide-class ops.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `A`  in  32: rs operand.
- `B`  in  32: rt operand.
- `MDUop`  in  4: operation code, sampled only when `start`=1.
- `start`  in  1: one-cycle request strobe from EX.
- `busy`  out  1: operation in flight.
- `HI`  out  32: HI register.
- `LO`  out  32: LO register.

## Operation
- Op codes:
  - 0000 none
  - 0001 mult (signed)
  - 0010 multu
  - 0011 div (signed)
  - 0100 divu
  - 0101 mthi
  - 0110 mtlo
  - 0111 madd, 1000 maddu, 1001 msub, 1010 msubu (these only with the macro in Configuration)
- Undefined or disabled codes with `start`=1 are no-ops.
- States:
  - IDLE: on `start` with a mult/div-class op, go to RUN. The result is computed from `A`, `B` at that edge and held in internal `hi_nx`/`lo_nx`. The counter loads the op's cycle count.
  - RUN: the counter decrements each edge. At the edge where it reaches 0, HI/LO take `hi_nx`/`lo_nx` and the state returns to IDLE.
- mult/multu: {HI,LO} = 64-bit product. Signed uses `$signed` on both operands sign-extended to 64 bits; unsigned uses zero-extension.
- div/divu: LO = quotient, HI = remainder. Signed truncates toward zero, and the remainder takes the dividend's sign.
  - Divide by zero: the op still runs `DIV_CYCLES` and HI/LO stay unchanged.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo: write `A` into HI/LO at the same edge `start` is sampled. No busy, no latency.
- `start` while `busy`=1 is ignored entirely, whatever the op; the CPU must stall instead.
- HI/LO are stable throughout RUN and show the previous values until commit.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0.
- `start` sampled at edge E0: `busy`=1 for exactly N cycles (edges E0..E(N-1) leave it high). At edge EN, HI/LO update and `busy`=0 in the same cycle.
- N = `MULT_CYCLES` for mult-class ops, `DIV_CYCLES` for div-class ops.
- A new `start` is accepted in the first cycle after `busy` falls. Back-to-back ops have no dead cycle.
- `reset` during RUN aborts the op: next cycle `busy`=0 and HI=LO=0, and the pending result is discarded.
- `reset` and `start` in the same cycle: reset wins.
- `busy` is registered. HI/LO are registered outputs with no combinational path from `A`/`B`.

## Configuration
- `MDU_MADD_EN` defined:
  - Ops 0111–1010 are legal, with `MULT_CYCLES` latency.
  - madd/maddu: {HI,LO} += signed/unsigned product.
  - msub/msubu: {HI,LO} -= product, mod 2^64.
  - The accumulate operand is the {HI,LO} value at commit time, which equals the value at start because HI/LO are frozen during RUN.
- `MDU_MADD_EN` not defined: those codes are treated as no-ops, and the accumulate adder is not synthesized.

## Structure
- Shared package `mdu_pkg`: the 4-bit op-code constants, state encoding (IDLE/RUN), and default cycle counts. The decoder in the controller imports the same op codes.
- One sub-module is natural: `mdu_calc`. It is combinational, takes op/A/B/HI/LO, and returns the 64-bit `{hi_nx, lo_nx}` plus an op-class flag. The top keeps the FSM, counter and registers.

## Test plan
- mult A=0xFFFFFFFF, B=2 -> `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. With multu, HI=1, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. With divu: LO=0x7FFFFFFC, HI=1.
- divu A=5, B=0 -> busy for 10 cycles, and HI/LO keep their prior values (preload HI=0x11, LO=0x22 via mthi/mtlo).
- mult started, then a second `start` (mtlo A=0x55) at cycle 2 of RUN -> ignored; LO equals the product after commit, not 0x55.
- `reset` asserted at cycle 3 of a div -> next cycle `busy`=0, HI=LO=0, and no later commit.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged and `busy` stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states, op classes and default latencies for the multiply/divide unit.
// No logic; the controller decoder and mdu_calc both import these.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'h0;
    localparam logic [3:0] OP_MULT  = 4'h1;
    localparam logic [3:0] OP_MULTU = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_DIVU  = 4'h4;
    localparam logic [3:0] OP_MTHI  = 4'h5;
    localparam logic [3:0] OP_MTLO  = 4'h6;
    localparam logic [3:0] OP_MADD  = 4'h7;
    localparam logic [3:0] OP_MADDU = 4'h8;
    localparam logic [3:0] OP_MSUB  = 4'h9;
    localparam logic [3:0] OP_MSUBU = 4'hA;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV
    } op_cls_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/div/accumulate datapath; returns the 64-bit {hi_nx, lo_nx} and the op class.
// Latency: none (pure logic). Backpressure: none; the parent only samples it on an accepted start.
// MDU_MADD_EN adds madd/maddu/msub/msubu accumulating into the current {hi, lo}.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output op_cls_e     cls
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn_div;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both flavours: signed divide works on magnitudes
    // and fixes signs afterwards, so 0x80000000 / -1 needs no special case.
    assign sgn_div = (op == OP_DIV);
    assign dvd     = (sgn_div && a[31]) ? (32'd0 - a) : a;
    assign dvs     = (sgn_div && b[31]) ? (32'd0 - b) : b;
    assign q       = dvd / dvs;
    assign r       = dvd % dvs;
    assign quo_s   = (a[31] ^ b[31]) ? (32'd0 - q) : q;
    assign rem_s   = a[31] ? (32'd0 - r) : r;

    always_comb begin
        res = {hi, lo};
        cls = CLS_NONE;
        case (op)
            OP_MULT:  begin res = prod_s; cls = CLS_MUL; end
            OP_MULTU: begin res = prod_u; cls = CLS_MUL; end
            OP_DIV: begin
                cls = CLS_DIV;
                if (b != 32'd0) res = {rem_s, quo_s};
            end
            OP_DIVU: begin
                cls = CLS_DIV;
                if (b != 32'd0) res = {r, q};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res = {hi, lo} + prod_s; cls = CLS_MUL; end
            OP_MADDU: begin res = {hi, lo} + prod_u; cls = CLS_MUL; end
            OP_MSUB:  begin res = {hi, lo} - prod_s; cls = CLS_MUL; end
            OP_MSUBU: begin res = {hi, lo} - prod_u; cls = CLS_MUL; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; optional MDU_MADD_EN enables accumulate ops.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, commit on the edge busy falls; mthi/mtlo immediate.
// Backpressure: none; start while busy is dropped, the hazard unit must stall on start | busy.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    state_e      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0] hi_nx, lo_nx, hi_nx_d, lo_nx_d;
    logic [31:0] hi_d, lo_d;
    logic [63:0] calc_res;
    op_cls_e     calc_cls;

    mdu_calc u_calc (
        .op  (MDUop),
        .a   (A),
        .b   (B),
        .hi  (HI),
        .lo  (LO),
        .res (calc_res),
        .cls (calc_cls)
    );

    assign busy = (state == S_RUN);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hi_nx_d = hi_nx;
        lo_nx_d = lo_nx;
        hi_d    = HI;
        lo_d    = LO;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (calc_cls != CLS_NONE) begin
                        state_d = S_RUN;
                        cnt_d   = (calc_cls == CLS_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        {hi_nx_d, lo_nx_d} = calc_res;
                    end else if (MDUop == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUop == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = hi_nx;
                    lo_d    = lo_nx;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_nx <= '0;
            lo_nx <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            hi_nx <= hi_nx_d;
            lo_nx <= lo_nx_d;
            HI    <= hi_d;
            LO    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu with hand-computed HI/LO values and busy-length checks.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUop;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int errs   = 0;
    int checks = 0;
    logic [31:0] m_hi, m_lo;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUop (MDUop),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left just after a falling edge; the next op may issue immediately.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n = 0;
        MDUop = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == 1) begin
                chk({tag, " hi frozen"}, HI, m_hi);
                chk({tag, " lo frozen"}, LO, m_lo);
            end
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(ncyc));
        chk({tag, " hi"}, HI, ehi);
        chk({tag, " lo"}, LO, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic move(input string tag, input logic [3:0] op, input logic [31:0] a);
        MDUop = op; A = a; B = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == OP_MTHI) m_hi = a;
        else               m_lo = a;
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, HI, m_hi);
        chk({tag, " lo"}, LO, m_lo);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; MDUop = OP_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", HI, 32'd0);
        chk("reset lo", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Back-to-back issue: each op starts in the cycle busy falls.
        run_op("mult",  OP_MULT,  32'hFFFFFFFF, 32'd2, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5,  32'h00000001, 32'hFFFFFFFE);
        run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  OP_DIVU,  32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
        run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("div pos/neg", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("mult neg*neg", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'h00000000, 32'h0000000F);

        move("mthi", OP_MTHI, 32'h11);
        move("mtlo", OP_MTLO, 32'h22);
        run_op("divu by 0", OP_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("undef op", 4'hF, 32'd3, 32'd3, 0, 32'h11, 32'h22);

        // mtlo during RUN must be dropped entirely.
        MDUop = OP_MULT; A = 32'd3; B = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) break;
            n++;
            if (n == 2) begin
                MDUop = OP_MTLO; A = 32'h55; start = 1'b1;
            end
        end
        chk("ignore busy cycles", 32'(n), 32'd5);
        chk("ignore hi", HI, 32'd0);
        chk("ignore lo", LO, 32'h0000000C);

        // Reset in the third busy cycle of a divide aborts it.
        MDUop = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", HI, 32'd0);
        chk("abort lo", LO, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort late busy", {31'd0, busy}, 32'd0);
        chk("abort late lo", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset and start in the same cycle: reset wins.
        reset = 1'b1; MDUop = OP_MTHI; A = 32'h99; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst+start hi", HI, 32'd0);
        chk("rst+start busy", {31'd0, busy}, 32'd0);

        move("pre mthi", OP_MTHI, 32'd0);
        move("pre mtlo", OP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'h00000001, 32'h00000000);
        run_op("msubu", OP_MSUBU, 32'd1, 32'd1, 5, 32'h00000000, 32'hFFFFFFFF);
        run_op("madd neg", OP_MADD, 32'hFFFFFFFF, 32'd1, 5, 32'h00000000, 32'hFFFFFFFE);
`else
        run_op("maddu off", OP_MADDU, 32'd1, 32'd1, 0, 32'h00000000, 32'hFFFFFFFF);
        run_op("msubu off", OP_MSUBU, 32'd1, 32'd1, 0, 32'h00000000, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
